// File: rtl/dense_cmd_decoder_if.sv
// Word-serial command stream channel for dense_cmd_decoder.
// The producer drives in_data/in_valid; the decoder drives in_ready.
// A word transfers on a rising edge where in_valid and in_ready are both high.
interface dense_cmd_decoder_if #(
  parameter int unsigned data_size = 16
);
  logic [data_size-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/dense_cmd_decoder.sv
// dense_cmd_decoder: parses a word-serial command stream (header, optional
// index/cost words, one or two size-element vectors) and presents the decoded
// bundle with a one-cycle out_valid for the downstream register stage.
// Optional feature macro: DENSE_CMD_DECODER_ERR_EN (sticky unknown-opcode err).
module dense_cmd_decoder #(
  parameter int unsigned size            = 3,
  parameter int unsigned data_size       = 16,
  parameter int unsigned cost_type_size  = 8,
  parameter int unsigned dense_type_size = 4,
  parameter int unsigned act_type_size   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  dense_cmd_decoder_if.slave          cmd,
  output logic [act_type_size-1:0]    act_type,
  output logic [dense_type_size-1:0]  dense_type,
  output logic [cost_type_size-1:0]   cost_type,
  output logic [data_size*size-1:0]   w,
  output logic [data_size*size-1:0]   x,
  output logic [data_size*size-1:0]   label,
  output logic [31:0]                 w_layer_index,
  output logic [31:0]                 w_row_index,
  output logic                        is_update,
  output logic                        load_w,
  output logic                        backprop_cost,
  output logic                        out_valid,
  output logic                        err
);

  localparam logic [3:0] OPC_LOAD_W  = 4'h1;
  localparam logic [3:0] OPC_FORWARD = 4'h2;
  localparam logic [3:0] OPC_TRAIN   = 4'h3;
  localparam logic [3:0] OPC_UPDATE  = 4'h4;

  // Counter must hold 0..3 for the index words and 0..size-1 for vectors.
  localparam int unsigned CW = (size > 4) ? $clog2(size) : 2;

  typedef enum logic [2:0] {HDR, IDX, COST, VEC_A, VEC_B, EMIT} state_t;
  typedef enum logic [1:0] {K_LOAD_W, K_FORWARD, K_TRAIN, K_UPDATE} kind_t;

  state_t          state, state_n;
  kind_t           kind;
  logic [CW-1:0]   cnt;
  logic            ready, acc, last_vec;
  logic [3:0]      opcode;

  assign opcode       = cmd.in_data[15:12];
  assign ready        = (state != EMIT) && !reset;
  assign acc          = cmd.in_valid && ready;
  assign cmd.in_ready = ready;
  assign last_vec     = (cnt == CW'(size - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= HDR;
    else       state <= state_n;
  end

  // Next-state decode and EMIT-cycle control pulses.
  always_comb begin
    state_n       = state;
    out_valid     = 1'b0;
    load_w        = 1'b0;
    backprop_cost = 1'b0;
    is_update     = 1'b0;
    case (state)
      HDR: begin
        if (acc) begin
          case (opcode)
            OPC_LOAD_W:  state_n = IDX;
            OPC_FORWARD: state_n = VEC_A;
            OPC_TRAIN:   state_n = COST;
            OPC_UPDATE:  state_n = EMIT;
            default:     state_n = HDR;
          endcase
        end
      end
      IDX:   if (acc && cnt == CW'(3)) state_n = VEC_A;
      COST:  if (acc) state_n = VEC_A;
      VEC_A: if (acc && last_vec) state_n = (kind == K_TRAIN) ? VEC_B : EMIT;
      VEC_B: if (acc && last_vec) state_n = EMIT;
      EMIT: begin
        out_valid     = 1'b1;
        load_w        = (kind == K_LOAD_W);
        backprop_cost = (kind == K_TRAIN);
        is_update     = (kind == K_UPDATE);
        state_n       = HDR;
      end
      default: state_n = HDR;
    endcase
  end

  // Word counter, command kind and field registers written as words arrive.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      kind          <= K_FORWARD;
      act_type      <= '0;
      dense_type    <= '0;
      cost_type     <= '0;
      w             <= '0;
      x             <= '0;
      label         <= '0;
      w_layer_index <= '0;
      w_row_index   <= '0;
    end else begin
      if (state_n != state)
        cnt <= '0;
      else if (acc && (state inside {IDX, VEC_A, VEC_B}))
        cnt <= cnt + CW'(1);

      if (acc) begin
        case (state)
          HDR: begin
            case (opcode)
              OPC_LOAD_W: kind <= K_LOAD_W;
              OPC_UPDATE: kind <= K_UPDATE;
              OPC_FORWARD, OPC_TRAIN: begin
                kind       <= (opcode == OPC_TRAIN) ? K_TRAIN : K_FORWARD;
                act_type   <= cmd.in_data[act_type_size-1:0];
                dense_type <= cmd.in_data[4 +: dense_type_size];
              end
              default: ;
            endcase
          end
          IDX: begin
            case (cnt)
              CW'(0):  w_layer_index[31:16] <= cmd.in_data[15:0];
              CW'(1):  w_layer_index[15:0]  <= cmd.in_data[15:0];
              CW'(2):  w_row_index[31:16]   <= cmd.in_data[15:0];
              default: w_row_index[15:0]    <= cmd.in_data[15:0];
            endcase
          end
          COST: cost_type <= cmd.in_data[cost_type_size-1:0];
          VEC_A: begin
            for (int unsigned k = 0; k < size; k++) begin
              if (cnt == CW'(k)) begin
                if (kind == K_LOAD_W) w[k*data_size +: data_size] <= cmd.in_data;
                else                  x[k*data_size +: data_size] <= cmd.in_data;
              end
            end
          end
          VEC_B: begin
            for (int unsigned k = 0; k < size; k++)
              if (cnt == CW'(k)) label[k*data_size +: data_size] <= cmd.in_data;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DENSE_CMD_DECODER_ERR_EN
  logic err_q;
  logic hdr_unknown;
  assign hdr_unknown = !(opcode inside {OPC_LOAD_W, OPC_FORWARD, OPC_TRAIN, OPC_UPDATE});

  // Sticky flag: any accepted header with an unrecognised opcode.
  always_ff @(posedge clk) begin
    if (reset)                                 err_q <= 1'b0;
    else if (state == HDR && acc && hdr_unknown) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
